// File: rtl/alu_sequencer_if.sv
// Command/response bus of the ALU sequencer.
// Handshake: a transfer happens on a rising clk edge where valid and ready
// are both high. A source raising valid keeps its payload stable until that
// edge; ready may depend on state but never on the same-cycle valid.
interface alu_sequencer_if #(
    parameter int WIDTH = 64
);
    logic             cmd_valid;
    logic             cmd_ready;
    logic [3:0]       cmd_op;
    logic [WIDTH-1:0] cmd_a;
    logic [WIDTH-1:0] cmd_b;

    logic             rsp_valid;
    logic             rsp_ready;
    logic [WIDTH-1:0] rsp_data;
    logic             rsp_z;
    logic             rsp_err;

    // Requester side: issues commands, consumes responses.
    modport master (
        output cmd_valid, cmd_op, cmd_a, cmd_b, rsp_ready,
        input  cmd_ready, rsp_valid, rsp_data, rsp_z, rsp_err
    );

    // Sequencer side: accepts commands, produces responses.
    modport slave (
        input  cmd_valid, cmd_op, cmd_a, cmd_b, rsp_ready,
        output cmd_ready, rsp_valid, rsp_data, rsp_z, rsp_err
    );
endinterface

// File: rtl/alu_sequencer.sv
// ALU sequencer: takes one command at a time, drives the external
// combinational ALU, and returns the captured result. MUL (op 1000) is
// built from repeated ALU adds using shift-and-add over the multiplier bits.
module alu_sequencer #(
    parameter int WIDTH  = 64,
    parameter bit MUL_EN = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    alu_sequencer_if.slave   bus,
    output logic [WIDTH-1:0] alu_num1,
    output logic [WIDTH-1:0] alu_num2,
    output logic [3:0]       alu_op,
    input  logic [WIDTH-1:0] alu_out,
    input  logic             alu_z,
    output logic [1:0]       dbg_state
);

    localparam logic [3:0] OP_AND  = 4'b0000;
    localparam logic [3:0] OP_OR   = 4'b0001;
    localparam logic [3:0] OP_ADD  = 4'b0010;
    localparam logic [3:0] OP_SUB  = 4'b0110;
    localparam logic [3:0] OP_PASS = 4'b0111;
    localparam logic [3:0] OP_NOR  = 4'b1100;
    localparam logic [3:0] OP_MUL  = 4'b1000;

    // Iteration counter must reach WIDTH-1.
    localparam int CW = $clog2(WIDTH) + 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        MUL  = 2'd2,
        RESP = 2'd3
    } state_t;

    state_t state;
    state_t next_state;

    // Latched command
    logic [3:0]       op_q;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;

    // Shift-add multiplier state
    logic [WIDTH-1:0] acc;
    logic [WIDTH-1:0] mcand;
    logic [WIDTH-1:0] mplier;
    logic [CW-1:0]    iter_cnt;

    // Held response
    logic [WIDTH-1:0] rsp_data_q;
    logic             rsp_z_q;
    logic             rsp_err_q;

    // Control strobes from the FSM
    logic accept;
    logic cmd_is_single;
    logic cmd_is_mul;
    logic mul_done;

    // Classify the incoming command op as a plain ALU op, a MUL, or illegal.
    always_comb begin
        cmd_is_single = 1'b0;
        cmd_is_mul    = 1'b0;
        case (bus.cmd_op)
            OP_AND, OP_OR, OP_ADD, OP_SUB, OP_PASS, OP_NOR: cmd_is_single = 1'b1;
            OP_MUL:  cmd_is_mul = MUL_EN;
            default: cmd_is_single = 1'b0;
        endcase
    end

    // MUL finishes once no set multiplier bits remain after this step,
    // or after the WIDTH-th iteration.
    always_comb begin
        mul_done = ((mplier >> 1) == '0) || (iter_cnt == CW'(WIDTH - 1));
    end

    // FSM state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state logic plus handshake and ALU drive; ALU idles at PASS-B of zeros.
    always_comb begin
        next_state    = state;
        accept        = 1'b0;
        bus.cmd_ready = 1'b0;
        bus.rsp_valid = 1'b0;
        alu_num1      = '0;
        alu_num2      = '0;
        alu_op        = OP_PASS;
        case (state)
            IDLE: begin
                bus.cmd_ready = ~rst;
                if (bus.cmd_valid && !rst) begin
                    accept = 1'b1;
                    if (cmd_is_single) begin
                        next_state = EXEC;
                    end else if (cmd_is_mul) begin
                        next_state = MUL;
                    end else begin
                        next_state = RESP;
                    end
                end
            end
            EXEC: begin
                alu_num1   = a_q;
                alu_num2   = b_q;
                alu_op     = op_q;
                next_state = RESP;
            end
            MUL: begin
                alu_num1 = acc;
                alu_num2 = mplier[0] ? mcand : '0;
                alu_op   = OP_ADD;
                if (mul_done) begin
                    next_state = RESP;
                end
            end
            RESP: begin
                bus.rsp_valid = 1'b1;
                if (bus.rsp_ready) begin
                    next_state = IDLE;
                end
            end
            default: next_state = IDLE;
        endcase
    end

    // Datapath: latch commands, step the multiplier, capture results.
    always_ff @(posedge clk) begin
        if (rst) begin
            op_q       <= OP_PASS;
            a_q        <= '0;
            b_q        <= '0;
            acc        <= '0;
            mcand      <= '0;
            mplier     <= '0;
            iter_cnt   <= '0;
            rsp_data_q <= '0;
            rsp_z_q    <= 1'b0;
            rsp_err_q  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        op_q     <= bus.cmd_op;
                        a_q      <= bus.cmd_a;
                        b_q      <= bus.cmd_b;
                        acc      <= '0;
                        mcand    <= bus.cmd_a;
                        mplier   <= bus.cmd_b;
                        iter_cnt <= '0;
                        if (!cmd_is_single && !cmd_is_mul) begin
                            // Illegal op: answer immediately, ALU untouched.
                            rsp_err_q  <= 1'b1;
                            rsp_data_q <= '0;
                            rsp_z_q    <= 1'b1;
                        end else begin
                            rsp_err_q <= 1'b0;
                        end
                    end
                end
                EXEC: begin
                    rsp_data_q <= alu_out;
                    rsp_z_q    <= alu_z;
                end
                MUL: begin
                    acc      <= alu_out;
                    mcand    <= mcand << 1;
                    mplier   <= mplier >> 1;
                    iter_cnt <= iter_cnt + 1'b1;
                    if (mul_done) begin
                        // Zero flag computed here; alu_z refers to the add, not the product.
                        rsp_data_q <= alu_out;
                        rsp_z_q    <= (alu_out == '0);
                    end
                end
                default: begin
                    rsp_data_q <= rsp_data_q;
                end
            endcase
        end
    end

    // Response payload comes straight from the held registers.
    always_comb begin
        bus.rsp_data = rsp_data_q;
        bus.rsp_z    = rsp_z_q;
        bus.rsp_err  = rsp_err_q;
        dbg_state    = state;
    end

endmodule
